// File: rtl/icache_refill_pkg.sv
// Shared icache geometry and RAM port widths for the refill engine.
// Optional flush support in icache_refill is enabled with ICACHE_REFILL_FLUSH_EN.
package icache_refill_pkg;

  localparam int ICACHE_BLK_WIDTH    = 512;
  localparam int ICACHE_BLK_BYTES    = ICACHE_BLK_WIDTH / 8;
  localparam int ICACHE_OFFSET_RANGE = $clog2(ICACHE_BLK_BYTES);
  localparam int ADDR_WIDTH          = 32;
  localparam int RAM_DATA_WIDTH      = 8;

  typedef logic [RAM_DATA_WIDTH-1:0] ram_byte_t;

  function automatic int offsetBits(input int blkBytes);
    return $clog2(blkBytes);
  endfunction

endpackage

// File: rtl/icache_refill_if.sv
// Byte-wide RAM read port between the refill engine (master) and the memory arbiter (slave).
interface icache_refill_if
  import icache_refill_pkg::*;
#(
  parameter int ADDR_W = ADDR_WIDTH
) ();

  logic              ram_req;
  logic              ram_gnt;
  logic [ADDR_W-1:0] ram_a;
  ram_byte_t         ram_din;

  modport master (output ram_req, output ram_a, input ram_gnt, input ram_din);
  modport slave  (input ram_req, input ram_a, output ram_gnt, output ram_din);

endinterface

// File: rtl/icache_refill_asm.sv
// Block assembler: byte index counter, issued-byte tracking and the slot array the
// returning RAM bytes are written into; exposes the next-state block so a fill can include the last byte.
module icache_refill_asm
  import icache_refill_pkg::*;
#(
  parameter int BLK_BYTES = ICACHE_BLK_BYTES,
  localparam int OFF_W    = offsetBits(BLK_BYTES),
  localparam int IDX_W    = OFF_W + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy_i,
  input  logic                   start_i,
  input  logic                   issue_i,
  input  ram_byte_t              din_i,
  output logic [IDX_W-1:0]       idx_o,
  output logic                   last_o,
  output logic [BLK_BYTES*8-1:0] blkD_o
);

  logic [IDX_W-1:0]                idx_q, idx_d;
  logic                            issued_q, issued_d;
  logic [OFF_W-1:0]                issIdx_q, issIdx_d;
  logic [BLK_BYTES-1:0][7:0]       slots_q, slots_d;

  // A byte on din_i belongs to the index issued in the previous ready cycle;
  // with rdy_i low nothing moves, so the pending capture simply waits.
  always_comb begin
    idx_d    = idx_q;
    issued_d = issued_q;
    issIdx_d = issIdx_q;
    slots_d  = slots_q;
    if (rdy_i) begin
      if (issued_q) slots_d[issIdx_q] = din_i;
      issued_d = issue_i;
      if (issue_i) begin
        issIdx_d = idx_q[OFF_W-1:0];
        idx_d    = idx_q + 1'b1;
      end
      if (start_i) idx_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q    <= '0;
      issued_q <= 1'b0;
      issIdx_q <= '0;
      slots_q  <= '0;
    end else begin
      idx_q    <= idx_d;
      issued_q <= issued_d;
      issIdx_q <= issIdx_d;
      slots_q  <= slots_d;
    end
  end

  assign idx_o  = idx_q;
  assign last_o = (idx_q == IDX_W'(BLK_BYTES - 1));
  assign blkD_o = slots_d;

endmodule

// File: rtl/icache_refill.sv
// Icache refill engine: fetches one block byte-by-byte over the arbitrated RAM port and
// returns it as a one-cycle fill pulse. Define ICACHE_REFILL_FLUSH_EN to add the flush_in abort input.
module icache_refill
  import icache_refill_pkg::*;
#(
  parameter int BLK_BYTES = ICACHE_BLK_BYTES,
  parameter int ADDR_W    = ADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   miss_in,
  input  logic [ADDR_W-1:0]      miss_addr,
`ifdef ICACHE_REFILL_FLUSH_EN
  input  logic                   flush_in,
`endif
  output logic                   fill_en,
  output logic [ADDR_W-1:0]      fill_addr,
  output logic [BLK_BYTES*8-1:0] fill_data,
  icache_refill_if.master        ram
);

  localparam int OFF_W = offsetBits(BLK_BYTES);
  localparam int IDX_W = OFF_W + 1;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(BLK_BYTES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_COOL  = 3'd5;

  logic [2:0]             state_q, state_d;
  logic [ADDR_W-1:0]      baseAddr_q, baseAddr_d;
  logic                   ramReq_q, ramReq_d;
  logic [ADDR_W-1:0]      fillAddr_q, fillAddr_d;
  logic [BLK_BYTES*8-1:0] fillData_q, fillData_d;
  logic                   start, issue, flush, lastIdx;
  logic [IDX_W-1:0]       idx;
  logic [BLK_BYTES*8-1:0] blkD;

`ifdef ICACHE_REFILL_FLUSH_EN
  assign flush = flush_in;
`else
  assign flush = 1'b0;
`endif

  // Everything is gated by rdy_in so a low global ready freezes the whole engine.
  always_comb begin
    state_d    = state_q;
    baseAddr_d = baseAddr_q;
    ramReq_d   = ramReq_q;
    fillAddr_d = fillAddr_q;
    fillData_d = fillData_q;
    start      = 1'b0;
    issue      = 1'b0;
    if (rdy_in) begin
      case (state_q)
        S_IDLE: if (miss_in && !flush) begin
          baseAddr_d = miss_addr & ~OFF_MASK;
          ramReq_d   = 1'b1;
          start      = 1'b1;
          state_d    = S_REQ;
        end
        S_REQ: begin
          if (flush) begin
            ramReq_d = 1'b0;
            state_d  = S_COOL;
          end else if (ram.ram_gnt) begin
            state_d = S_READ;
          end
        end
        S_READ: begin
          if (flush) begin
            ramReq_d = 1'b0;
            state_d  = S_COOL;
          end else begin
            issue = 1'b1;
            if (lastIdx) state_d = S_DRAIN;
          end
        end
        S_DRAIN: begin
          ramReq_d = 1'b0;
          if (flush) begin
            state_d = S_COOL;
          end else begin
            fillAddr_d = baseAddr_q;
            fillData_d = blkD;
            state_d    = S_DONE;
          end
        end
        S_DONE:  state_d = S_COOL;
        S_COOL:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      baseAddr_q <= '0;
      ramReq_q   <= 1'b0;
      fillAddr_q <= '0;
      fillData_q <= '0;
    end else begin
      state_q    <= state_d;
      baseAddr_q <= baseAddr_d;
      ramReq_q   <= ramReq_d;
      fillAddr_q <= fillAddr_d;
      fillData_q <= fillData_d;
    end
  end

  icache_refill_asm #(
    .BLK_BYTES(BLK_BYTES)
  ) u_asm (
    .clk    (clk),
    .rst    (rst_in),
    .rdy_i  (rdy_in),
    .start_i(start),
    .issue_i(issue),
    .din_i  (ram.ram_din),
    .idx_o  (idx),
    .last_o (lastIdx),
    .blkD_o (blkD)
  );

  // The base is block-aligned, so OR-ing in the index never carries into the tag.
  assign ram.ram_a   = (state_q == S_READ) ? (baseAddr_q | ADDR_W'(idx)) : '0;
  assign ram.ram_req = ramReq_q;
  assign fill_en     = (state_q == S_DONE);
  assign fill_addr   = fillAddr_q;
  assign fill_data   = fillData_q;

endmodule
